// File: rtl/inst_packer.sv
// rtl/inst_packer.sv - LEGv8 instruction encoder with immediate range check and tagged output FIFO
module inst_packer #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [63:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [7:0]        err_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [2:0] KIND_LDUR = 3'd0;
    localparam logic [2:0] KIND_STUR = 3'd1;
    localparam logic [2:0] KIND_CBZ  = 3'd2;
    localparam logic [2:0] KIND_ADDI = 3'd3;
    localparam logic [2:0] KIND_CBNZ = 3'd4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;

    logic [31:0]       instr_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem  [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic              full;
    logic              accept;
    logic              push;
    logic              pop;
    logic [31:0]       packed_word;
    logic              legal;

    // A value fits a signed W-bit field when every bit from W-1 upward is a copy of the sign
    logic fits9;
    logic fits12;
    logic fits19;

    assign fits9  = (&in_imm[63:8])  | ~(|in_imm[63:8]);
    assign fits12 = (&in_imm[63:11]) | ~(|in_imm[63:11]);
    assign fits19 = (&in_imm[63:18]) | ~(|in_imm[63:18]);

    // Pack the request into its 32-bit encoding and decide whether it is encodable
    always_comb begin
        packed_word = 32'd0;
        legal       = 1'b0;
        case (in_kind)
            KIND_LDUR: begin
                packed_word = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
                legal       = fits9;
            end
            KIND_STUR: begin
                packed_word = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
                legal       = fits9;
            end
            KIND_CBZ: begin
                packed_word = {8'b10110100, in_imm[18:0], in_rd};
                legal       = fits19;
            end
            KIND_CBNZ: begin
                packed_word = {8'b10110101, in_imm[18:0], in_rd};
                legal       = fits19;
            end
            KIND_ADDI: begin
                packed_word = {10'b1001000100, in_imm[11:0], in_rn, in_rd};
                legal       = fits12;
            end
            default: begin
                packed_word = 32'd0;
                legal       = 1'b0;
            end
        endcase
    end

    // Ready never looks at out_ready, so a full FIFO stalls the producer for one extra cycle
    assign full      = (count == FULL_COUNT);
    assign in_ready  = !reset && (state == RUN) && !full && !clear;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_instr = instr_mem[rd_ptr];
    assign out_addr  = addr_mem[rd_ptr];

    // Control FSM: address tagging, error capture and RUN/HALT sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            wr_addr   <= '0;
            err       <= 1'b0;
            err_count <= 8'd0;
        end else if (clear) begin
            state   <= RUN;
            wr_addr <= '0;
            err     <= 1'b0;
        end else if (accept) begin
            if (legal) begin
                wr_addr <= wr_addr + 1'b1;
            end else begin
                err   <= 1'b1;
                state <= HALT;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

    // Output FIFO storage and pointers; clear drops everything including a same-cycle pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= 32'd0;
                addr_mem[i]  <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= packed_word;
                addr_mem[wr_ptr]  <= wr_addr;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_packer.sv
// tb/tb_inst_packer.sv - scoreboard bench for inst_packer
module tb_inst_packer;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rn;
    logic [63:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic        err;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;

    logic [39:0] exp_q[$];
    logic [7:0]  addr_model;

    inst_packer #(.DEPTH(2), .ADDR_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_rd     (in_rd),
        .in_rn     (in_rn),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err),
        .err_count (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake at the output is matched against the scoreboard head
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {32'd0, out_instr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                chk("out_instr", {32'd0, out_instr}, {32'd0, e[39:8]});
                chk("out_addr", {56'd0, out_addr}, {56'd0, e[7:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [63:0] imm, input logic [31:0] exp, input bit legal);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        in_kind  = k;
        in_rd    = rd;
        in_rn    = rn;
        in_imm   = imm;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
                if (legal) begin
                    exp_q.push_back({exp, addr_model});
                    addr_model = addr_model + 8'd1;
                end
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk("drained_empty", {63'd0, out_valid}, 64'd0);
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear      = 1'b0;
        addr_model = 8'd0;
        exp_q.delete();
    endtask

    initial begin
        reset      = 1'b1;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_kind    = 3'd0;
        in_rd      = 5'd0;
        in_rn      = 5'd0;
        in_imm     = 64'd0;
        out_ready  = 1'b0;
        addr_model = 8'd0;
        #3;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
        chk("rst_out_addr", {56'd0, out_addr}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_err_count", {56'd0, err_count}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        tick();
        reset = 1'b0;

        // LDUR latency and hold while stalled
        send(3'd0, 5'd1, 5'd2, -64'sd8, 32'hF85F8041, 1);
        @(negedge clk);
        chk("lat_valid", {63'd0, out_valid}, 64'd1);
        chk("lat_instr", {32'd0, out_instr}, 64'hF85F8041);
        chk("lat_addr", {56'd0, out_addr}, 64'd0);
        @(negedge clk);
        chk("hold_instr", {32'd0, out_instr}, 64'hF85F8041);
        tick();
        drain();
        do_clear();

        // Streaming with consumer always ready, plus boundary immediates
        out_ready = 1'b1;
        send(3'd3, 5'd3, 5'd4, 64'd5, 32'h91001483, 1);
        send(3'd2, 5'd5, 5'd0, -64'sd1, 32'hB4FFFFE5, 1);
        send(3'd1, 5'd7, 5'd8, 64'd255, 32'hF80FF107, 1);
        send(3'd4, 5'd0, 5'd0, 64'd262143, 32'hB57FFFE0, 1);
        send(3'd0, 5'd0, 5'd0, -64'sd256, 32'hF8500000, 1);
        send(3'd3, 5'd31, 5'd31, -64'sd2048, 32'h912003FF, 1);
        drain();
        do_clear();

        // Full FIFO backpressure with no ready bypass
        out_ready = 1'b0;
        send(3'd3, 5'd3, 5'd4, 64'd5, 32'h91001483, 1);
        send(3'd2, 5'd5, 5'd0, -64'sd1, 32'hB4FFFFE5, 1);
        in_valid = 1'b1;
        in_kind  = 3'd1;
        in_rd    = 5'd7;
        in_rn    = 5'd8;
        in_imm   = 64'd255;
        @(negedge clk);
        chk("full_ready", {63'd0, in_ready}, 64'd0);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_no_bypass", {63'd0, in_ready}, 64'd0);
        tick();
        @(negedge clk);
        chk("ready_after_pop", {63'd0, in_ready}, 64'd1);
        exp_q.push_back({32'hF80FF107, addr_model});
        addr_model = addr_model + 8'd1;
        tick();
        in_valid = 1'b0;
        drain();
        do_clear();

        // Out-of-range immediate halts; queued word still drains; clear recovers
        out_ready = 1'b0;
        send(3'd4, 5'd0, 5'd0, 64'd262143, 32'hB57FFFE0, 1);
        send(3'd0, 5'd1, 5'd2, 64'd256, 32'h0, 0);
        in_valid = 1'b1;
        in_kind  = 3'd3;
        in_imm   = 64'd1;
        @(negedge clk);
        chk("halt_err", {63'd0, err}, 64'd1);
        chk("halt_err_count", {56'd0, err_count}, 64'd1);
        chk("halt_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        in_valid = 1'b0;
        drain();
        @(negedge clk);
        chk("halt_persist", {63'd0, in_ready}, 64'd0);
        tick();
        do_clear();
        @(negedge clk);
        chk("clr_err", {63'd0, err}, 64'd0);
        chk("clr_in_ready", {63'd0, in_ready}, 64'd1);
        chk("clr_err_count_kept", {56'd0, err_count}, 64'd1);
        tick();
        out_ready = 1'b1;
        send(3'd0, 5'd1, 5'd2, -64'sd8, 32'hF85F8041, 1);
        drain();

        // Illegal kind together with clear is not accepted
        in_valid = 1'b1;
        in_kind  = 3'd6;
        clear    = 1'b1;
        @(negedge clk);
        chk("clr_wins_ready", {63'd0, in_ready}, 64'd0);
        tick();
        clear      = 1'b0;
        in_valid   = 1'b0;
        addr_model = 8'd0;
        @(negedge clk);
        chk("clr_wins_err", {63'd0, err}, 64'd0);
        chk("clr_wins_err_count", {56'd0, err_count}, 64'd1);
        tick();

        // Address tag wraps after 256 words
        out_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            logic [11:0] iv;
            logic [4:0]  rdv;
            iv  = 12'(i);
            rdv = 5'(i);
            send(3'd3, rdv, 5'd0, 64'(i), {10'b1001000100, iv, 5'd0, rdv}, 1);
        end
        drain();

        // Asynchronous reset with a full FIFO
        out_ready = 1'b0;
        send(3'd1, 5'd7, 5'd8, 64'd255, 32'hF80FF107, 1);
        send(3'd4, 5'd0, 5'd0, 64'd262143, 32'hB57FFFE0, 1);
        @(negedge clk);
        chk("pre_rst_full", {63'd0, in_ready}, 64'd0);
        tick();
        reset = 1'b1;
        #2;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_err", {63'd0, err}, 64'd0);
        chk("mid_rst_err_count", {56'd0, err_count}, 64'd0);
        chk("mid_rst_out_instr", {32'd0, out_instr}, 64'd0);
        exp_q.delete();
        addr_model = 8'd0;
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        send(3'd3, 5'd31, 5'd31, -64'sd2048, 32'h912003FF, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
